// File: rtl/mmu_seg_if.sv
// Request/response and configuration bus of the segment MMU.
// The master side drives requests and configuration writes; the slave side is the MMU.
interface mmu_seg_if #(
    parameter int AW   = 32,
    parameter int NSEG = 4
);
    localparam int SB = $clog2(NSEG);

    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_va;
    logic          req_we;
    logic          resp_valid;
    logic [AW-1:0] resp_pa;
    logic          resp_fault;
    logic [AW-1:0] fault_va;
    logic          fault_clr;
    logic          cfg_we;
    logic [SB-1:0] cfg_idx;
    logic [1:0]    cfg_sel;
    logic [AW-1:0] cfg_wdata;

    modport master (
        output req_valid, req_va, req_we, fault_clr,
        output cfg_we, cfg_idx, cfg_sel, cfg_wdata,
        input  req_ready, resp_valid, resp_pa, resp_fault, fault_va
    );

    modport slave (
        input  req_valid, req_va, req_we, fault_clr,
        input  cfg_we, cfg_idx, cfg_sel, cfg_wdata,
        output req_ready, resp_valid, resp_pa, resp_fault, fault_va
    );
endinterface

// File: rtl/mmu_seg.sv
// Segmented MMU: top address bits select a segment, the offset is bounds-checked
// against its limit and relocated by its base, with a one-cycle response.
module mmu_seg #(
    parameter int AW   = 32,
    parameter int PW   = 24,
    parameter int NSEG = 4
) (
    input  logic       clk,
    input  logic       reset,
    mmu_seg_if.slave   bus
);
    localparam int SB = $clog2(NSEG);
    localparam int OW = AW - SB;

    // state | meaning
    // RUN   | accepting translation requests
    // FAULT | a translation faulted; requests stalled until fault_clr
    typedef enum logic {RUN, FAULT} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   base_q  [NSEG];
    logic [PW-1:0]   base_d  [NSEG];
    logic [OW-1:0]   limit_q [NSEG];
    logic [OW-1:0]   limit_d [NSEG];
    logic [NSEG-1:0] seg_v_q, seg_v_d;
    logic [NSEG-1:0] wp_q, wp_d;
    logic            en_q, en_d;
    logic            resp_valid_q, resp_valid_d;
    logic            resp_fault_q, resp_fault_d;
    logic [AW-1:0]   resp_pa_q, resp_pa_d;
    logic [AW-1:0]   fault_va_q, fault_va_d;

    logic [SB-1:0]   seg_idx;
    logic [OW-1:0]   seg_off;
    logic [PW-1:0]   seg_pa;
    logic            accept;
    logic            fault_hit;
    logic            unused_cfg_bits;

    assign unused_cfg_bits = ^bus.cfg_wdata[AW-1:OW];

    always_comb begin
        base_d  = base_q;
        limit_d = limit_q;
        seg_v_d = seg_v_q;
        wp_d    = wp_q;
        en_d    = en_q;
        if (bus.cfg_we) begin
            case (bus.cfg_sel)
                2'd0: base_d[bus.cfg_idx]  = bus.cfg_wdata[PW-1:0];
                2'd1: limit_d[bus.cfg_idx] = bus.cfg_wdata[OW-1:0];
                2'd2: begin
                    seg_v_d[bus.cfg_idx] = bus.cfg_wdata[0];
                    wp_d[bus.cfg_idx]    = bus.cfg_wdata[1];
                end
                default: en_d = bus.cfg_wdata[0];
            endcase
        end
    end

    // Translation reads the registered config, so a same-edge write lands after it.
    always_comb begin
        seg_idx   = bus.req_va[AW-1:OW];
        seg_off   = bus.req_va[OW-1:0];
        seg_pa    = base_q[seg_idx] + PW'(seg_off);
        fault_hit = en_q && (!seg_v_q[seg_idx] || (seg_off >= limit_q[seg_idx]) ||
                             (bus.req_we && wp_q[seg_idx]));
        accept    = bus.req_valid && (state_q == RUN);

        resp_valid_d = accept;
        resp_fault_d = accept && fault_hit;
        resp_pa_d    = '0;
        if (accept && !fault_hit)
            resp_pa_d = en_q ? AW'(seg_pa) : AW'(bus.req_va[PW-1:0]);

        fault_va_d = fault_va_q;
        if (accept && fault_hit)
            fault_va_d = bus.req_va;

        state_d = state_q;
        case (state_q)
            RUN:     if (accept && fault_hit) state_d = FAULT;
            FAULT:   if (bus.fault_clr)       state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RUN;
            base_q       <= '{default: '0};
            limit_q      <= '{default: '0};
            seg_v_q      <= '0;
            wp_q         <= '0;
            en_q         <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_pa_q    <= '0;
            fault_va_q   <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            limit_q      <= limit_d;
            seg_v_q      <= seg_v_d;
            wp_q         <= wp_d;
            en_q         <= en_d;
            resp_valid_q <= resp_valid_d;
            resp_fault_q <= resp_fault_d;
            resp_pa_q    <= resp_pa_d;
            fault_va_q   <= fault_va_d;
        end
    end

    assign bus.req_ready  = (state_q == RUN);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_fault = resp_fault_q;
    assign bus.resp_pa    = resp_pa_q;
    assign bus.fault_va   = fault_va_q;
endmodule

// File: tb/tb_mmu_seg.sv
// Directed bench for mmu_seg (AW=32, PW=24, NSEG=4) with hand-computed expectations.
module tb_mmu_seg;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   nvec = 0;
    int   nfail = 0;

    mmu_seg_if #(.AW(32), .NSEG(4)) bus ();

    mmu_seg #(.AW(32), .PW(24), .NSEG(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [1:0] idx, input logic [1:0] sel, input logic [31:0] data);
        bus.cfg_we    = 1'b1;
        bus.cfg_idx   = idx;
        bus.cfg_sel   = sel;
        bus.cfg_wdata = data;
        tick();
        bus.cfg_we = 1'b0;
    endtask

    task automatic do_req(input logic [31:0] va, input logic we);
        bus.req_valid = 1'b1;
        bus.req_va    = va;
        bus.req_we    = we;
        tick();
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
    endtask

    task automatic clr();
        bus.fault_clr = 1'b1;
        tick();
        bus.fault_clr = 1'b0;
    endtask

    initial begin
        bus.req_valid = 0; bus.req_va = '0; bus.req_we = 0; bus.fault_clr = 0;
        bus.cfg_we = 0; bus.cfg_idx = '0; bus.cfg_sel = '0; bus.cfg_wdata = '0;
        #1 reset = 1'b1;
        #1;
        chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        chk("rst_req_ready",  {31'b0, bus.req_ready},  32'd1);
        chk("rst_resp_pa",    bus.resp_pa,             32'h0);
        chk("rst_fault_va",   bus.fault_va,            32'h0);
        #10 reset = 1'b0;

        // Pass-through with translation disabled
        do_req(32'hFFAB_CDEF, 1'b0);
        chk("pt_valid", {31'b0, bus.resp_valid}, 32'd1);
        chk("pt_pa",    bus.resp_pa,             32'h00AB_CDEF);
        chk("pt_fault", {31'b0, bus.resp_fault}, 32'd0);
        tick();
        chk("idle_valid", {31'b0, bus.resp_valid}, 32'd0);
        chk("idle_pa",    bus.resp_pa,             32'h0);

        // Seg1 setup
        cfg(2'd1, 2'd0, 32'h0010_0000);
        cfg(2'd1, 2'd1, 32'h0000_1000);
        cfg(2'd1, 2'd2, 32'h0000_0001);
        cfg(2'd0, 2'd3, 32'h0000_0001);
        do_req(32'h4000_0234, 1'b0);
        chk("seg1_pa",    bus.resp_pa,             32'h0010_0234);
        chk("seg1_fault", {31'b0, bus.resp_fault}, 32'd0);

        // Limit fault, stall, clear
        do_req(32'h4000_1000, 1'b0);
        chk("lim_fault",    {31'b0, bus.resp_fault}, 32'd1);
        chk("lim_pa",       bus.resp_pa,             32'h0);
        chk("lim_fault_va", bus.fault_va,            32'h4000_1000);
        chk("lim_ready",    {31'b0, bus.req_ready},  32'd0);
        do_req(32'h4000_0004, 1'b0);
        chk("stall_ready", {31'b0, bus.req_ready},  32'd0);
        chk("stall_valid", {31'b0, bus.resp_valid}, 32'd0);
        clr();
        chk("clr_ready",    {31'b0, bus.req_ready},  32'd1);
        chk("clr_valid",    {31'b0, bus.resp_valid}, 32'd0);
        chk("hold_fault_va", bus.fault_va,           32'h4000_1000);
        clr();
        chk("clr_run_ready", {31'b0, bus.req_ready}, 32'd1);

        // Write protect
        cfg(2'd1, 2'd2, 32'h0000_0003);
        do_req(32'h4000_0010, 1'b1);
        chk("wp_fault",    {31'b0, bus.resp_fault}, 32'd1);
        chk("wp_fault_va", bus.fault_va,            32'h4000_0010);
        clr();
        do_req(32'h4000_0010, 1'b0);
        chk("wp_load_pa",    bus.resp_pa,             32'h0010_0010);
        chk("wp_load_fault", {31'b0, bus.resp_fault}, 32'd0);

        // Wrap and last in-range offset
        cfg(2'd1, 2'd0, 32'h00FF_FFF0);
        do_req(32'h4000_0020, 1'b0);
        chk("wrap_pa", bus.resp_pa, 32'h0000_0010);
        do_req(32'h4000_0FFF, 1'b0);
        chk("edge_pa",    bus.resp_pa,             32'h0000_0FEF);
        chk("edge_fault", {31'b0, bus.resp_fault}, 32'd0);

        // Zero limit faults every access
        cfg(2'd1, 2'd1, 32'h0);
        do_req(32'h4000_0000, 1'b0);
        chk("lim0_fault", {31'b0, bus.resp_fault}, 32'd1);
        clr();
        cfg(2'd1, 2'd1, 32'h0000_1000);

        // Invalid segment
        do_req(32'h8000_0000, 1'b0);
        chk("inv_fault",    {31'b0, bus.resp_fault}, 32'd1);
        chk("inv_fault_va", bus.fault_va,            32'h8000_0000);
        clr();

        // Config write on the same edge as a request
        bus.cfg_we = 1'b1; bus.cfg_idx = 2'd1; bus.cfg_sel = 2'd0; bus.cfg_wdata = 32'h0020_0000;
        do_req(32'h4000_0004, 1'b0);
        bus.cfg_we = 1'b0;
        chk("same_edge_old", bus.resp_pa, 32'h00FF_FFF4);
        do_req(32'h4000_0004, 1'b0);
        chk("same_edge_new", bus.resp_pa, 32'h0020_0004);

        // Disabled: no faults even on invalid-segment stores; back-to-back requests
        cfg(2'd3, 2'd3, 32'h0);
        do_req(32'h8012_3456, 1'b1);
        chk("dis_pa",    bus.resp_pa,             32'h0012_3456);
        chk("dis_fault", {31'b0, bus.resp_fault}, 32'd0);
        bus.req_valid = 1'b1; bus.req_va = 32'h0000_0001;
        tick();
        chk("b2b_1", bus.resp_pa, 32'h0000_0001);
        bus.req_va = 32'h0000_0002;
        tick();
        chk("b2b_2",       bus.resp_pa,             32'h0000_0002);
        chk("b2b_2_valid", {31'b0, bus.resp_valid}, 32'd1);

        // Reset during the response cycle
        bus.req_va = 32'h4000_0234;
        tick();
        bus.req_valid = 1'b0;
        chk("pre_rst_valid", {31'b0, bus.resp_valid}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_drop_valid", {31'b0, bus.resp_valid}, 32'd0);
        chk("rst_drop_pa",    bus.resp_pa,             32'h0);
        chk("rst_fault_va2",  bus.fault_va,            32'h0);
        #1 reset = 1'b0;
        tick();
        chk("post_rst_valid", {31'b0, bus.resp_valid}, 32'd0);
        cfg(2'd1, 2'd2, 32'h1);
        cfg(2'd0, 2'd3, 32'h1);
        do_req(32'h4000_0000, 1'b0);
        chk("post_rst_lim_cleared", {31'b0, bus.resp_fault}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
